fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC, drives the instruction-memory request/`ihit` handshake, and loads the IF/ID pipeline register. It sits directly upstream of decode and consumes the hazard unit's `pc_enable`/`enable_ID`/`flush_ID` controls plus the MEM-stage jump redirect. A one-entry skid register holds an instruction that returns while decode is stalled.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/if_id_skid.sv | 35 +++
 rtl/fetch_stage.sv | 147 ++++++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline front end: word, fetch FSM states and R-type field layout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } r_t;

    localparam word_t WORD_BYTES  = 32'd4;
    localparam word_t ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_id_skid.sv
// One-entry holding register for an instruction that returned while decode was stalled.
module if_id_skid
    import cpu_types_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  load_i,
    input  logic  clear_i,
    input  word_t instr_i,
    input  word_t pc4_i,
    output word_t instr_o,
    output word_t pc4_o
);

    word_t instr_q;
    word_t pc4_q;

    // Clear doubles as drain: once the entry moves into IF/ID it is dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instr_q <= '0;
            pc4_q   <= '0;
        end else if (clear_i) begin
            instr_q <= '0;
            pc4_q   <= '0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem request/ihit handshake, IF/ID register and skid entry.
//   state  | meaning
//   IDLE   | just out of reset, no request yet
//   FETCH  | requesting imem[PC], waiting for ihit
//   HOLD   | skid holds a returned instruction, decode stalled
//   HALTED | sticky stop after HALT, left only by reset
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  pc_enable,
    input  logic  enable_ID,
    input  logic  flush_ID,
    input  logic  stall_mem,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output word_t instr_ID,
    output word_t pc4_ID,
    output logic  valid_ID
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        instr_q, instr_d;
    word_t        pc4_q, pc4_d;
    logic         valid_q, valid_d;

    logic  advance;
    logic  skid_load;
    logic  skid_clear;
    word_t skid_instr;
    word_t skid_pc4;
    word_t pc_plus4;

    assign advance  = enable_ID & ~pc_enable & ~stall_mem;
    assign pc_plus4 = pc_q + WORD_BYTES;

    if_id_skid u_skid (
        .clk_i   (CLK),
        .rst_n_i (nRST),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .instr_i (imemload),
        .pc4_i   (pc_plus4),
        .instr_o (skid_instr),
        .pc4_o   (skid_pc4)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            pc_q    <= PC_INIT;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (ihit) begin
                    pc_d = pc_plus4;
                    if (advance) begin
                        instr_d = imemload;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (advance) begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (advance) begin
                    instr_d    = skid_instr;
                    pc4_d      = skid_pc4;
                    valid_d    = 1'b1;
                    skid_clear = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: ;
        endcase

        // Later overrides win, so these appear in increasing priority order.
        if (flush_ID) begin
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
        end

        if (redirect && (state_q != HALTED)) begin
            pc_d       = redirect_pc & ALIGN_MASK;
            instr_d    = '0;
            pc4_d      = '0;
            valid_d    = 1'b0;
            skid_load  = 1'b0;
            skid_clear = 1'b1;
            state_d    = FETCH;
        end

        if (halt || (state_q == HALTED)) begin
            pc_d       = pc_q;
            instr_d    = '0;
            pc4_d      = '0;
            valid_d    = 1'b0;
            skid_load  = 1'b0;
            skid_clear = 1'b1;
            state_d    = HALTED;
        end
    end

    assign imemREN  = (state_q == FETCH);
    assign imemaddr = pc_q;
    assign instr_ID = instr_q;
    assign pc4_ID   = pc4_q;
    assign valid_ID = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a queue-based fetch model.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit = 1'b0;
    logic [31:0] imemload = '0;
    logic        pc_enable = 1'b0;
    logic        enable_ID = 1'b1;
    logic        flush_ID = 1'b0;
    logic        stall_mem = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic [31:0] instr_ID;
    logic [31:0] pc4_ID;
    logic        valid_ID;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .pc_enable(pc_enable),
        .enable_ID(enable_ID), .flush_ID(flush_ID), .stall_mem(stall_mem),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .instr_ID(instr_ID), .pc4_ID(pc4_ID), .valid_ID(valid_ID)
    );

    // Reference model: PC, IF/ID contents, started/halted flags, pending-instruction queue.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_started, m_halted;
    logic [63:0] skq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
        m_started = 1'b0; m_halted = 1'b0;
        skq.delete();
    endtask

    task automatic bubble();
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic adv;
        adv = enable_ID & ~pc_enable & ~stall_mem;
        if (m_halted) begin
        end else if (halt) begin
            m_halted = 1'b1; bubble(); skq.delete();
        end else if (redirect) begin
            m_pc = {redirect_pc[31:2], 2'b00}; bubble(); skq.delete(); m_started = 1'b1;
        end else begin
            if (!m_started) begin
                m_started = 1'b1;
            end else if (skq.size() == 0) begin
                if (ihit) begin
                    if (adv) begin
                        m_instr = imemload; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                    end else begin
                        skq.push_back({imemload, m_pc + 32'd4});
                    end
                    m_pc = m_pc + 32'd4;
                end else if (adv) begin
                    bubble();
                end
            end else if (adv) begin
                {m_instr, m_pc4} = skq.pop_front();
                m_valid = 1'b1;
            end
            if (flush_ID) bubble();
        end
    endtask

    task automatic check_all();
        chk("imemREN",  32'(imemREN),  32'(m_started && !m_halted && skq.size() == 0));
        chk("imemaddr", imemaddr,      m_pc);
        chk("instr_ID", instr_ID,      m_instr);
        chk("pc4_ID",   pc4_ID,        m_pc4);
        chk("valid_ID", 32'(valid_ID), 32'(m_valid));
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic quiet();
        ihit = 1'b0; pc_enable = 1'b0; enable_ID = 1'b1; flush_ID = 1'b0;
        stall_mem = 1'b0; redirect = 1'b0; halt = 1'b0;
    endtask

    initial begin
        int halted_cycles;
        model_reset();
        quiet();
        #2;
        check_all();
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // Streaming fetch with every request hit and decode advancing.
        for (int k = 1; k <= 3; k++) begin
            ihit = 1'b1; imemload = $urandom;
            tick();
            chk("stream_pc4", pc4_ID, 32'd4 * k);
        end

        // Decode stalled: instruction parks in skid, then drains.
        imemload = 32'h8C22_0004; enable_ID = 1'b0;
        tick();
        chk("hold_ren", 32'(imemREN), 32'd0);
        imemload = $urandom;
        tick();
        tick();
        enable_ID = 1'b1; ihit = 1'b0;
        tick();
        chk("skid_instr", instr_ID, 32'h8C22_0004);
        chk("skid_pc", imemaddr, 32'd16);

        // Redirect while holding drops the skid entry.
        enable_ID = 1'b0; ihit = 1'b1; imemload = $urandom;
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        chk("redir_addr", imemaddr, 32'h0000_0100);
        chk("redir_valid", 32'(valid_ID), 32'd0);
        redirect = 1'b0; enable_ID = 1'b1; imemload = $urandom;
        tick();
        chk("redir_pc4", pc4_ID, 32'h0000_0104);

        flush_ID = 1'b1; imemload = $urandom;
        tick();
        chk("flush_instr", instr_ID, 32'h0);
        chk("flush_addr", imemaddr, 32'h0000_0108);
        flush_ID = 1'b0;

        // PC wraps past the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0; imemload = $urandom;
        tick();
        chk("wrap_addr", imemaddr, 32'h0);
        chk("wrap_pc4", pc4_ID, 32'h0);

        halt = 1'b1;
        tick();
        halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0040;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("halt_ren", 32'(imemREN), 32'd0);
        end
        redirect = 1'b0;

        // Reset lands mid-access with ihit high.
        ihit = 1'b1; imemload = $urandom;
        do_reset();
        tick();

        halted_cycles = 0;
        for (int n = 0; n < 600; n++) begin
            ihit        = ($urandom_range(0, 3) != 0);
            imemload    = $urandom;
            pc_enable   = ($urandom_range(0, 5) == 0);
            enable_ID   = ($urandom_range(0, 3) != 0);
            flush_ID    = ($urandom_range(0, 7) == 0);
            stall_mem   = ($urandom_range(0, 7) == 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = $urandom;
            halt        = ($urandom_range(0, 79) == 0);
            if (m_halted) halted_cycles++;
            if (halted_cycles > 4) begin
                halted_cycles = 0;
                do_reset();
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
